// File: rtl/ofifo.sv
// +----------------------------------------------------------------------------
// | ofifo : per-column output FIFO collecting skewed psum rows from the array
// | rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic                   o_overflow
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [aw:0]            rptr;
  logic [col-1:0]         full;
  logic [col-1:0]         empty;
  logic [col-1:0]         accept;
  logic [col*psum_bw-1:0] head;
  logic                   pop;

  generate
    for (genvar i = 0; i < col; i++) begin : g_lane
      logic [psum_bw-1:0] mem [depth];
      logic [aw:0]        wptr;

      assign full[i]   = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
      assign empty[i]  = (wptr == rptr);
      assign accept[i] = wr[i] & ~full[i];
      assign head[psum_bw*i +: psum_bw] = mem[rptr[aw-1:0]];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wptr <= '0;
        end else if (accept[i]) begin
          wptr <= wptr + ptr_one;
        end
      end

      // Storage is deliberately not reset; the pointers define what is live.
      always_ff @(posedge clk) begin
        if (accept[i]) begin
          mem[wptr[aw-1:0]] <= in[psum_bw*i +: psum_bw];
        end
      end
    end
  endgenerate

  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr       <= '0;
      out        <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (pop) begin
        rptr <= rptr + ptr_one;
        out  <= head;
      end
      if (|(wr & full)) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ofifo.sv
// Directed self-checking bench for ofifo (col=8, psum_bw=16, depth=64).
`default_nettype none

module tb_ofifo;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in;
  logic [7:0]   wr;
  logic         rd;
  logic [127:0] out;
  logic         o_full;
  logic         o_ready;
  logic         o_valid;
  logic         o_overflow;

  int checks = 0;
  int errors = 0;

  ofifo #(.col(8), .psum_bw(16), .depth(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .wr         (wr),
    .rd         (rd),
    .out        (out),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row with lane i = base + i.
  function automatic logic [127:0] mkrow(input int base);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(base + i);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in = '0; wr = '0; rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",   out,                128'(0));
    check("rst_valid", 128'(o_valid),      128'(0));
    check("rst_full",  128'(o_full),       128'(0));
    check("rst_ready", 128'(o_ready),      128'(1));
    check("rst_ovf",   128'(o_overflow),   128'(0));
    reset = 1'b0;

    // Pop on empty is ignored.
    rd = 1'b1; tick(); rd = 1'b0;
    check("empty_rd_out",   out,              128'(0));
    check("empty_rd_valid", 128'(o_valid),    128'(0));
    check("empty_rd_ovf",   128'(o_overflow), 128'(0));

    // Single full-width row.
    in = mkrow(16'h0100); wr = 8'hFF; tick(); wr = 8'h00;
    check("row_valid", 128'(o_valid), 128'(1));
    check("row_full",  128'(o_full),  128'(0));
    rd = 1'b1; tick(); rd = 1'b0;
    check("row_out",     out,           mkrow(16'h0100));
    check("row_valid_0", 128'(o_valid), 128'(0));

    // Skewed column writes.
    in = mkrow(1);
    for (int i = 0; i < 8; i++) begin
      wr = 8'(1 << i); tick();
      check("skew_valid", 128'(o_valid), 128'(i == 7));
    end
    wr = 8'h00;
    rd = 1'b1; tick(); rd = 1'b0;
    check("skew_out", out, mkrow(1));

    // Fill to depth, then overflow.
    wr = 8'hFF;
    for (int k = 0; k < 64; k++) begin
      in = mkrow(k * 16); tick();
      if (k == 62) check("fill_not_full", 128'(o_full), 128'(0));
    end
    check("fill_full",  128'(o_full),     128'(1));
    check("fill_ready", 128'(o_ready),    128'(0));
    check("fill_ovf0",  128'(o_overflow), 128'(0));
    in = mkrow(16'hF000); tick(); wr = 8'h00;
    check("ovf_set",  128'(o_overflow), 128'(1));
    check("ovf_full", 128'(o_full),     128'(1));
    rd = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick();
      check("drain_out", out, mkrow(k * 16));
    end
    rd = 1'b0;
    check("drain_valid",  128'(o_valid),    128'(0));
    check("drain_full",   128'(o_full),     128'(0));
    check("ovf_sticky",   128'(o_overflow), 128'(1));

    // Steady-state streaming across pointer wrap.
    reset = 1'b1; #2; reset = 1'b0;
    check("rst2_ovf", 128'(o_overflow), 128'(0));
    in = mkrow(0); wr = 8'hFF; tick();
    rd = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      in = mkrow(n * 8); tick();
      check("stream_out",   out,           mkrow((n - 1) * 8));
      check("stream_valid", 128'(o_valid), 128'(1));
    end
    rd = 1'b0; wr = 8'h00;
    check("stream_ovf",  128'(o_overflow), 128'(0));
    check("stream_full", 128'(o_full),     128'(0));

    // Asynchronous reset with rows stored.
    wr = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      in = mkrow(16'h4000 + k * 8); tick();
    end
    wr = 8'h00;
    #3 reset = 1'b1;
    #1;
    check("async_valid", 128'(o_valid), 128'(0));
    check("async_out",   out,           128'(0));
    #1 reset = 1'b0;
    wr = 8'hFF;
    in = mkrow(16'h5000); tick();
    in = mkrow(16'h6000); tick();
    wr = 8'h00;
    rd = 1'b1;
    tick(); check("post_rst_a", out, mkrow(16'h5000));
    tick(); check("post_rst_b", out, mkrow(16'h6000));
    rd = 1'b0;
    check("post_rst_empty", 128'(o_valid), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
